// File: rtl/lsu_mem_ctrl_if.sv
// Core-request, response and single-port memory bus of the load/store controller.
// The slave modport is the controller's view; the master modport is the core/memory side.
interface lsu_mem_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [63:0]           i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic [DATA_WIDTH-1:0] o_resp_rdata;
  logic                  o_resp_misaligned;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_write_en;
  logic [DATA_WIDTH-1:0] o_mem_write_data;
  logic [DATA_WIDTH-1:0] i_mem_read_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_resp_ready, i_mem_read_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
    output o_mem_addr, o_mem_write_en, o_mem_write_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output i_resp_ready, i_mem_read_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_misaligned,
    input  o_mem_addr, o_mem_write_en, o_mem_write_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one access at a time, read-modify-write for
// stores narrower than a word, sign/zero extension of loads, misalignment trapping.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          i_clk,
  input  logic          i_arstn,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  misaligned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;

  logic                  accept;
  logic                  req_misaligned;
  logic [5:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [7:0]            size_mask;
  logic [7:0]            byte_en;
  logic [DATA_WIDTH-1:0] wdata_shifted;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_addr_hi;

  // Address bits above the memory window are dropped; wrap is by truncation.
  assign unused_addr_hi = ^bus.i_req_addr[63:ADDR_WIDTH];

  assign accept = (state_q == IDLE) && bus.i_req_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_misaligned = 1'b0;
    unique case (bus.i_req_size)
      2'd0: req_misaligned = 1'b0;
      2'd1: req_misaligned = bus.i_req_addr[0];
      2'd2: req_misaligned = |bus.i_req_addr[1:0];
      2'd3: req_misaligned = |bus.i_req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_misaligned ? RESP : READ;
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (bus.i_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      misaligned_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q         <= bus.i_req_we;
        size_q       <= bus.i_req_size;
        unsigned_q   <= bus.i_req_unsigned;
        misaligned_q <= req_misaligned;
        addr_q       <= bus.i_req_addr[ADDR_WIDTH-1:0];
        wdata_q      <= bus.i_req_wdata;
      end
      if (state_q == READ) word_q <= bus.i_mem_read_data;
    end
  end

  // Load path: bring the addressed bytes down to bit 0, then extend.
  assign shamt   = {addr_q[2:0], 3'b000};
  assign shifted = word_q >> shamt;

  always_comb begin
    load_ext = shifted;
    unique case (size_q)
      2'd0: load_ext = unsigned_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: load_ext = shifted;
      default: load_ext = shifted;
    endcase
  end

  // Store path: splice the right-aligned store data into the word read back in READ.
  always_comb begin
    size_mask = 8'h01;
    unique case (size_q)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  assign byte_en       = size_mask << addr_q[2:0];
  assign wdata_shifted = wdata_q << shamt;

  always_comb begin
    merged = word_q;
    for (int b = 0; b < 8; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = wdata_shifted[b*8 +: 8];
    end
  end

  assign bus.o_req_ready       = (state_q == IDLE);
  assign bus.o_resp_valid      = (state_q == RESP);
  assign bus.o_resp_misaligned = (state_q == RESP) && misaligned_q;
  assign bus.o_resp_rdata      = ((state_q == RESP) && !misaligned_q && !we_q) ? load_ext : '0;
  assign bus.o_mem_write_en    = (state_q == WRITE);
  assign bus.o_mem_write_data  = (state_q == WRITE) ? merged : '0;
  assign bus.o_mem_addr        = ((state_q == READ) || (state_q == WRITE))
                                 ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a word-wide behavioural memory answers the
// controller, and each access is checked for latency, data, strobes and address.
module tb_lsu_mem_ctrl;

  logic i_clk = 1'b0;
  logic i_arstn = 1'b0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .i_clk   (i_clk),
    .i_arstn (i_arstn),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [63:0] mem [128];
  int          wr_cnt = 0;
  logic [9:0]  last_waddr = '0;

  assign bus.i_mem_read_data = mem[bus.o_mem_addr[9:3]];

  always @(posedge i_clk) begin
    if (bus.o_mem_write_en) begin
      mem[bus.o_mem_addr[9:3]] = bus.o_mem_write_data;
      last_waddr = bus.o_mem_addr;
      wr_cnt = wr_cnt + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata);
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_addr     = addr;
    bus.i_req_wdata    = wdata;
  endtask

  // Issue one request at a negedge, measure accept-to-valid latency, check the response.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                         input int exp_lat, input logic [63:0] exp_rdata, input logic exp_mis,
                         input int exp_writes);
    int lat;
    int wr0;
    logic addr_seen;
    wr0 = wr_cnt;
    addr_seen = 1'b0;
    check({tag, "_ready"}, 64'(bus.o_req_ready), 64'd1);
    drive_req(we, size, uns, addr, wdata);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    lat = 1;
    while (!bus.o_resp_valid && lat < 10) begin
      if (bus.o_mem_addr != '0) addr_seen = 1'b1;
      @(negedge i_clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rdata"}, bus.o_resp_rdata, exp_rdata);
    check({tag, "_mis"}, 64'(bus.o_resp_misaligned), 64'(exp_mis));
    check({tag, "_busy"}, 64'(bus.o_req_ready), 64'd0);
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(exp_writes));
    if (exp_mis) check({tag, "_memaddr"}, 64'(addr_seen), 64'd0);
    bus.i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_resp_ready = 1'b0;
    check({tag, "_idle"}, 64'(bus.o_resp_valid), 64'd0);
  endtask

  initial begin
    int wr0;
    logic [63:0] held;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[2] = 64'h8877_6655_4433_2211;
    mem[4] = 64'hDEAD_BEEF_CAFE_F00D;
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_size     = 2'd0;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_req_wdata    = '0;
    bus.i_resp_ready   = 1'b0;

    repeat (3) @(negedge i_clk);
    check("rst_resp_valid", 64'(bus.o_resp_valid), 64'd0);
    check("rst_write_en", 64'(bus.o_mem_write_en), 64'd0);
    check("rst_mis", 64'(bus.o_resp_misaligned), 64'd0);
    check("rst_rdata", bus.o_resp_rdata, 64'd0);
    check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    check("rst_wdata", bus.o_mem_write_data, 64'd0);
    i_arstn = 1'b1;
    @(negedge i_clk);
    check("rel_ready", 64'(bus.o_req_ready), 64'd1);

    // Loads: sign/zero extension and byte lane selection.
    run_req("ld_b_s",  1'b0, 2'd0, 1'b0, 64'h17, '0, 2, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 0);
    run_req("ld_b_pos",1'b0, 2'd0, 1'b0, 64'h11, '0, 2, 64'h0000_0000_0000_0022, 1'b0, 0);
    run_req("ld_w_u",  1'b0, 2'd2, 1'b1, 64'h14, '0, 2, 64'h0000_0000_8877_6655, 1'b0, 0);
    run_req("ld_h_s",  1'b0, 2'd1, 1'b0, 64'h16, '0, 2, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 0);
    run_req("ld_d",    1'b0, 2'd3, 1'b0, 64'h10, '0, 2, 64'h8877_6655_4433_2211, 1'b0, 0);

    // Half store: read-modify-write of the containing word.
    run_req("st_h", 1'b1, 2'd1, 1'b0, 64'h12, 64'h0000_0000_0000_ABCD, 3, 64'd0, 1'b0, 1);
    check("st_h_waddr", 64'(last_waddr), 64'h10);
    check("st_h_word", mem[2], 64'h8877_6655_ABCD_2211);

    // Misaligned accesses never touch memory.
    run_req("mis_ld_w", 1'b0, 2'd2, 1'b0, 64'h06, '0, 1, 64'd0, 1'b1, 0);
    run_req("mis_st_h", 1'b1, 2'd1, 1'b0, 64'h13, 64'h5555, 1, 64'd0, 1'b1, 0);
    check("mis_st_word", mem[2], 64'h8877_6655_ABCD_2211);

    // Byte store with address bits above the window set: they are truncated away.
    run_req("st_b_hi", 1'b1, 2'd0, 1'b0, 64'h0000_0001_0000_0017, 64'h1234_5678_9ABC_DEEE,
            3, 64'd0, 1'b0, 1);
    check("st_b_word", mem[2], 64'hEE77_6655_ABCD_2211);

    // Backpressure: response held, new requests ignored.
    drive_req(1'b0, 2'd3, 1'b0, 64'h10, '0);
    @(posedge i_clk);
    @(negedge i_clk);
    drive_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h0BAD_0BAD_0BAD_0BAD);
    @(negedge i_clk);
    held = 64'hEE77_6655_ABCD_2211;
    wr0 = wr_cnt;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(bus.o_resp_valid), 64'd1);
      check("bp_rdata", bus.o_resp_rdata, held);
      check("bp_ready", 64'(bus.o_req_ready), 64'd0);
      @(negedge i_clk);
    end
    bus.i_req_valid  = 1'b0;
    bus.i_resp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_resp_ready = 1'b0;
    check("bp_release", 64'(bus.o_req_ready), 64'd1);
    repeat (4) @(negedge i_clk);
    check("bp_no_queue_valid", 64'(bus.o_resp_valid), 64'd0);
    check("bp_no_queue_write", 64'(wr_cnt - wr0), 64'd0);
    check("bp_word", mem[2], held);

    // Reset asserted in the WRITE cycle aborts the store.
    wr0 = wr_cnt;
    drive_req(1'b1, 2'd3, 1'b0, 64'h20, 64'h1111_2222_3333_4444);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    check("rw_read_addr", 64'(bus.o_mem_addr), 64'h20);
    @(negedge i_clk);
    check("rw_in_write", 64'(bus.o_mem_write_en), 64'd1);
    i_arstn = 1'b0;
    #1;
    check("rw_we_drop", 64'(bus.o_mem_write_en), 64'd0);
    check("rw_addr_drop", 64'(bus.o_mem_addr), 64'd0);
    check("rw_wdata_drop", bus.o_mem_write_data, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("rw_no_resp", 64'(bus.o_resp_valid), 64'd0);
    end
    i_arstn = 1'b1;
    @(negedge i_clk);
    check("rw_ready", 64'(bus.o_req_ready), 64'd1);
    check("rw_no_resp_after", 64'(bus.o_resp_valid), 64'd0);
    check("rw_no_write", 64'(wr_cnt - wr0), 64'd0);
    check("rw_word", mem[4], 64'hDEAD_BEEF_CAFE_F00D);

    run_req("post_rst_ld", 1'b0, 2'd3, 1'b1, 64'h20, '0, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
